vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator, the successor to the fixed 640x480 `vga` block. It produces horizontal and vertical sync, the display-area flag and beam counters from one system clock. Resolution, porches, sync widths, sync polarities and the pixel-clock divide ratio are all set by parameters. It adds a pixel-enable strobe, line/frame start pulses, active-area pixel coordinates and a run/pause input, and it feeds the background and sprite renderers.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync width (lines)
- `V_BACK`, 33, vertical back porch (lines)
- `HS_POL`, 0, hsync active level (0 = active-low)
- `VS_POL`, 0, vsync active level
- `CLK_DIV`, 1, clk cycles per pixel (≥1)
- `CW`, 10, counter width; H_TOTAL and V_TOTAL must each be ≤ 2^CW
- `clk` in 1: system clock. One clock; reset is asynchronous and active-high.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: 1 = run, 0 = hold all state.
- `vga_h_sync` out 1: hsync at HS_POL level.
- `vga_v_sync` out 1: vsync at VS_POL level.
- `inDisplayArea` out 1: beam is in the active region.
- `CounterX` out CW: horizontal beam position, 0..H_TOTAL-1.
- `CounterY` out CW: vertical beam position, 0..V_TOTAL-1.
- `pixel_x` out CW: equals CounterX when inDisplayArea=1, otherwise 0.
- `pixel_y` out CW: equals CounterY when inDisplayArea=1, otherwise 0.
- `pix_en` out 1: high for the first clk cycle of each new pixel.
- `line_start` out 1: pix_en && CounterX==0.
- `frame_start` out 1: pix_en && CounterX==0 && CounterY==0.

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK (800 by default). V_TOTAL is formed the same way (525 by default).
- Per-axis order is active, front porch, sync, back porch; position 0 is the first visible pixel or line.
- Divider `div_cnt` counts 0..CLK_DIV-1. The internal tick is `div_cnt==CLK_DIV-1 && enable`. With CLK_DIV=1 the tick is high on every enabled cycle.
- On a tick:
  - CounterX increments.
  - At H_TOTAL-1, CounterX wraps to 0 and CounterY increments.
  - When CounterY is at V_TOTAL-1 at that same wrap, it also wraps to 0.
- hsync window: CounterX in [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], which is [656,751] by default.
- vsync window: CounterY in [V_ACTIVE+V_FRONT, V_ACTIVE+V_FRONT+V_SYNC-1], which is [490,491] by default. vsync depends on CounterY only.
- inDisplayArea = CounterX<H_ACTIVE && CounterY<V_ACTIVE.
- enable=0:
  - div_cnt, the counters and all level outputs hold.
  - pix_en, line_start and frame_start are forced to 0.
  - On re-enable, counting resumes from the held div_cnt.
- All arithmetic is unsigned CW-bit. The compare constants are elaborated from the parameters; there are no runtime dividers.

## Timing
- Every output is a flop. The level outputs are decoded from the next-state counter values, so they are cycle-aligned with the CounterX/CounterY they describe (zero skew).
- Counters and level outputs change only on ticked edges. The strobes are high for exactly one clk, in the cycle immediately after a ticked edge.
- Reset value of every output:
  - CounterX = H_TOTAL-1, CounterY = V_TOTAL-1 (the last pixel of the frame).
  - inDisplayArea = 0, pixel_x = 0, pixel_y = 0.
  - vga_h_sync = ~HS_POL, vga_v_sync = ~VS_POL.
  - pix_en = 0, line_start = 0, frame_start = 0.
  - div_cnt = 0.
- The first tick after reset release moves the beam to (0,0) and raises frame_start.
  - CLK_DIV=1: frame_start is high in the first cycle after the first post-release edge.
  - General case: the first tick falls on the CLK_DIV-th edge after release.
- Frame period is CLK_DIV·H_TOTAL·V_TOTAL clk cycles; line period is CLK_DIV·H_TOTAL.
- Asserting reset mid-frame returns all outputs to their reset values immediately (asynchronously). No partial-line state survives.

## Structure
- Package `vga_timing_pkg` holds:
  - the default 640x480@60 constants;
  - a constant function `total(active,front,sync,back)`;
  - a constant function for the minimum CW.
- One sub-module, `vga_axis_counter`, instantiated twice (H and V).
  - Parameters: ACTIVE/FRONT/SYNC/BACK/POL/CW.
  - Inputs: `clk`, `reset`, `step`.
  - Outputs: `count`, `wrap`, `sync`, `active`.
  - The H instance's `step` is the tick. The V instance's `step` is the tick AND H `wrap`.
- The top level holds the divider, the strobe flops and the pixel_x/pixel_y masking.

## Test plan
- Reset check, default parameters: assert reset mid-run. Required, in the same cycle: CounterX=799, CounterY=524, syncs=1, inDisplayArea=0, all strobes 0. After release: first edge gives (0,0), with frame_start=1 and inDisplayArea=1 for one cycle.
- Line wrap: at CounterX=799, CounterY=5, the next tick gives CounterX=0, CounterY=6, line_start=1. hsync is 0 exactly for X=656..751, which is 96 pixels.
- Vertical window: vsync is 0 exactly for Y=490..491. inDisplayArea is 0 for all Y≥480. pixel_x and pixel_y are 0 whenever inDisplayArea=0. Frame length between frame_start pulses is 420000 clk cycles.
- CLK_DIV=2: pix_en has a period of 2 clk and a duty of one cycle. Frame length is 840000 clk cycles. Counters change only on ticked edges.
- Small parameter set (4/1/2/1 horizontal, 3/1/1/1 vertical), with HS_POL=1 and VS_POL=1:
  - H_TOTAL=8, V_TOTAL=6;
  - hsync is high for X=5..6;
  - vsync is high for Y=4;
  - frame_start repeats every 48 clk.
- Enable gating: drop enable for 10 cycles at (100,200). Required: all outputs hold and strobes are 0 throughout. After re-enable, the first tick gives (101,200).

Source files
------------

// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared constants and elaboration helpers for the VGA timing generator
package vga_timing_pkg;

    // 640x480 at 60 Hz with a 25 MHz pixel clock
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FRONT  = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BACK   = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FRONT  = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BACK   = 33;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;
    localparam int DEF_CLK_DIV  = 1;
    localparam int DEF_CW       = 10;

    // Positions per axis: active, front porch, sync, back porch
    function automatic int total(input int active, input int front, input int sync, input int back);
        return active + front + sync + back;
    endfunction

    // Smallest counter width that holds every position of both axes
    function automatic int min_cw(input int h_total, input int v_total);
        int m;
        m = (h_total > v_total) ? h_total : v_total;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: position counter with sync and active decode
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FRONT  = DEF_H_FRONT,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BACK   = DEF_H_BACK,
    parameter bit POL    = DEF_HS_POL,
    parameter int CW     = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_nxt,
    output logic          wrap,
    output logic          sync,
    output logic          active
);

    localparam int            TOTAL      = total(ACTIVE, FRONT, SYNC, BACK);
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(ACTIVE + FRONT);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(ACTIVE + FRONT + SYNC - 1);
    localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);

    logic [CW-1:0] r_count;
    logic          r_sync;
    logic          w_in_sync;

    // Position after this edge; wrap flags the last position so the next axis can step
    always_comb begin
        wrap      = (r_count == LAST);
        count_nxt = r_count;
        if (step) begin
            count_nxt = wrap ? '0 : r_count + CW'(1);
        end
    end

    // Decodes use the next position so they land in the same cycle as the count they describe
    assign w_in_sync = (count_nxt >= SYNC_FIRST) && (count_nxt <= SYNC_LAST);
    assign active    = (count_nxt < ACT_END);

    // Position and sync level registers; reset parks the beam on the last position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= LAST;
            r_sync  <= ~POL;
        end else if (step) begin
            r_count <= count_nxt;
            r_sync  <= w_in_sync ? POL : ~POL;
        end
    end

    assign count = r_count;
    assign sync  = r_sync;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FRONT  = DEF_H_FRONT,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BACK   = DEF_H_BACK,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FRONT  = DEF_V_FRONT,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BACK   = DEF_V_BACK,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    output logic          vga_h_sync,
    output logic          vga_v_sync,
    output logic          inDisplayArea,
    output logic [CW-1:0] CounterX,
    output logic [CW-1:0] CounterY,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          pix_en,
    output logic          line_start,
    output logic          frame_start
);

    localparam int            DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div_cnt;
    logic          r_in_display;
    logic [CW-1:0] r_pixel_x;
    logic [CW-1:0] r_pixel_y;
    logic          r_pix_en;
    logic          r_line_start;
    logic          r_frame_start;

    logic          w_tick;
    logic          w_v_step;
    logic          w_disp_nxt;
    logic [CW-1:0] w_h_cnt;
    logic [CW-1:0] w_h_cnt_nxt;
    logic          w_h_wrap;
    logic          w_h_sync;
    logic          w_h_act;
    logic [CW-1:0] w_v_cnt;
    logic [CW-1:0] w_v_cnt_nxt;
    logic          w_v_wrap;
    logic          w_v_sync;
    logic          w_v_act;

    // One tick per pixel; the divider freezes while disabled so a pause resumes mid-pixel
    assign w_tick   = enable && (r_div_cnt == DIV_LAST);
    assign w_v_step = w_tick && w_h_wrap;

    // Pixel clock divider
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_div_cnt <= '0;
        end else if (enable) begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + DW'(1);
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .POL    (HS_POL),
        .CW     (CW)
    ) u_h_axis (
        .clk       (clk),
        .reset     (reset),
        .step      (w_tick),
        .count     (w_h_cnt),
        .count_nxt (w_h_cnt_nxt),
        .wrap      (w_h_wrap),
        .sync      (w_h_sync),
        .active    (w_h_act)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .POL    (VS_POL),
        .CW     (CW)
    ) u_v_axis (
        .clk       (clk),
        .reset     (reset),
        .step      (w_v_step),
        .count     (w_v_cnt),
        .count_nxt (w_v_cnt_nxt),
        .wrap      (w_v_wrap),
        .sync      (w_v_sync),
        .active    (w_v_act)
    );

    assign w_disp_nxt = w_h_act && w_v_act;

    // Display flag and masked coordinates, registered from the next beam position
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_display <= 1'b0;
            r_pixel_x    <= '0;
            r_pixel_y    <= '0;
        end else if (w_tick) begin
            r_in_display <= w_disp_nxt;
            r_pixel_x    <= w_disp_nxt ? w_h_cnt_nxt : '0;
            r_pixel_y    <= w_disp_nxt ? w_v_cnt_nxt : '0;
        end
    end

    // Single-cycle strobes following each ticked edge; a wrap on both axes starts a frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pix_en      <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_pix_en      <= w_tick;
            r_line_start  <= w_tick && w_h_wrap;
            r_frame_start <= w_tick && w_h_wrap && w_v_wrap;
        end
    end

    assign vga_h_sync    = w_h_sync;
    assign vga_v_sync    = w_v_sync;
    assign inDisplayArea = r_in_display;
    assign CounterX      = w_h_cnt;
    assign CounterY      = w_v_cnt;
    assign pixel_x       = r_pixel_x;
    assign pixel_y       = r_pixel_y;
    assign pix_en        = r_pix_en;
    assign line_start    = r_line_start;
    assign frame_start   = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed self-checking bench for vga_timing_gen
module tb_vga_timing_gen;

    logic clk;
    logic reset;
    logic en_a, en_b, en_c, en_d, en_e;
    logic run;
    int   cyc;
    int   n_cmp;
    int   n_fail;

    // A: default 640x480
    logic       a_hs, a_vs, a_disp, a_pix, a_ls, a_fs;
    logic [9:0] a_x, a_y, a_px, a_py;
    // B: 120-pixel lines, default vertical, used for pause/resume
    logic       b_hs, b_vs, b_disp, b_pix, b_ls, b_fs;
    logic [9:0] b_x, b_y, b_px, b_py;
    // C: 20-pixel lines, default vertical
    logic       c_hs, c_vs, c_disp, c_pix, c_ls, c_fs;
    logic [9:0] c_x, c_y, c_px, c_py;
    // D: as C with CLK_DIV=2
    logic       d_hs, d_vs, d_disp, d_pix, d_ls, d_fs;
    logic [9:0] d_x, d_y, d_px, d_py;
    // E: 8x6 raster, positive syncs
    logic       e_hs, e_vs, e_disp, e_pix, e_ls, e_fs;
    logic [2:0] e_x, e_y, e_px, e_py;

    vga_timing_gen u_a (
        .clk(clk), .reset(reset), .enable(en_a),
        .vga_h_sync(a_hs), .vga_v_sync(a_vs), .inDisplayArea(a_disp),
        .CounterX(a_x), .CounterY(a_y), .pixel_x(a_px), .pixel_y(a_py),
        .pix_en(a_pix), .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(.H_ACTIVE(104), .H_FRONT(4), .H_SYNC(8), .H_BACK(4)) u_b (
        .clk(clk), .reset(reset), .enable(en_b),
        .vga_h_sync(b_hs), .vga_v_sync(b_vs), .inDisplayArea(b_disp),
        .CounterX(b_x), .CounterY(b_y), .pixel_x(b_px), .pixel_y(b_py),
        .pix_en(b_pix), .line_start(b_ls), .frame_start(b_fs)
    );

    vga_timing_gen #(.H_ACTIVE(16), .H_FRONT(1), .H_SYNC(2), .H_BACK(1)) u_c (
        .clk(clk), .reset(reset), .enable(en_c),
        .vga_h_sync(c_hs), .vga_v_sync(c_vs), .inDisplayArea(c_disp),
        .CounterX(c_x), .CounterY(c_y), .pixel_x(c_px), .pixel_y(c_py),
        .pix_en(c_pix), .line_start(c_ls), .frame_start(c_fs)
    );

    vga_timing_gen #(.H_ACTIVE(16), .H_FRONT(1), .H_SYNC(2), .H_BACK(1), .CLK_DIV(2)) u_d (
        .clk(clk), .reset(reset), .enable(en_d),
        .vga_h_sync(d_hs), .vga_v_sync(d_vs), .inDisplayArea(d_disp),
        .CounterX(d_x), .CounterY(d_y), .pixel_x(d_px), .pixel_y(d_py),
        .pix_en(d_pix), .line_start(d_ls), .frame_start(d_fs)
    );

    vga_timing_gen #(.H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
                     .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
                     .HS_POL(1'b1), .VS_POL(1'b1), .CW(3)) u_e (
        .clk(clk), .reset(reset), .enable(en_e),
        .vga_h_sync(e_hs), .vga_v_sync(e_vs), .inDisplayArea(e_disp),
        .CounterX(e_x), .CounterY(e_y), .pixel_x(e_px), .pixel_y(e_py),
        .pix_en(e_pix), .line_start(e_ls), .frame_start(e_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed statistics, gathered on the falling edge
    int a_hs_cnt, a_hs_first, a_hs_last;
    int c_fs_n, c_t0, c_t1, c_vs_cnt, c_vs_first, c_vs_last, c_disp_cnt, c_disp_bad, c_mask_bad;
    int d_fs_n, d_t0, d_t1, d_pix_cnt, d_pix_dbl, d_chg_bad;
    int e_fs_n, e_t0, e_t1, e_hs_cnt, e_hs_first, e_hs_last, e_vs_cnt, e_vs_first, e_vs_last;
    logic       d_pix_prev;
    logic [9:0] d_x_prev;

    // Line 3 of A: hsync low extent
    always @(negedge clk) begin
        if (run && a_y == 10'd3 && a_hs == 1'b0) begin
            if (a_hs_cnt == 0) a_hs_first <= int'(a_x);
            a_hs_last <= int'(a_x);
            a_hs_cnt  <= a_hs_cnt + 1;
        end
    end

    // First full frame of C: vsync window, display region and coordinate masking
    always @(negedge clk) begin
        if (run) begin
            if (c_fs) begin
                c_fs_n <= c_fs_n + 1;
                if (c_fs_n == 0) c_t0 <= cyc;
                if (c_fs_n == 1) c_t1 <= cyc;
            end
            if ((c_fs_n == 0 && c_fs) || (c_fs_n == 1 && !c_fs)) begin
                if (c_vs == 1'b0) begin
                    if (c_vs_cnt == 0) c_vs_first <= int'(c_y);
                    c_vs_last <= int'(c_y);
                    c_vs_cnt  <= c_vs_cnt + 1;
                end
                if (c_disp) c_disp_cnt <= c_disp_cnt + 1;
                if (c_disp && c_y >= 10'd480) c_disp_bad <= c_disp_bad + 1;
                if ((!c_disp && (c_px != 10'd0 || c_py != 10'd0)) ||
                    (c_disp && (c_px != c_x || c_py != c_y)))
                    c_mask_bad <= c_mask_bad + 1;
            end
        end
    end

    // First full frame of D: pixel strobe cadence and tick-only counter changes
    always @(negedge clk) begin
        if (run) begin
            if (d_fs) begin
                d_fs_n <= d_fs_n + 1;
                if (d_fs_n == 0) d_t0 <= cyc;
                if (d_fs_n == 1) d_t1 <= cyc;
            end
            if ((d_fs_n == 0 && d_fs) || (d_fs_n == 1 && !d_fs)) begin
                if (d_pix) d_pix_cnt <= d_pix_cnt + 1;
                if (d_pix && d_pix_prev) d_pix_dbl <= d_pix_dbl + 1;
                if (d_x != d_x_prev && !d_pix) d_chg_bad <= d_chg_bad + 1;
            end
            d_pix_prev <= d_pix;
            d_x_prev   <= d_x;
        end
    end

    // First full frame of E: positive sync extents
    always @(negedge clk) begin
        if (run) begin
            if (e_fs) begin
                e_fs_n <= e_fs_n + 1;
                if (e_fs_n == 0) e_t0 <= cyc;
                if (e_fs_n == 1) e_t1 <= cyc;
            end
            if ((e_fs_n == 0 && e_fs) || (e_fs_n == 1 && !e_fs)) begin
                if (e_hs) begin
                    if (e_hs_cnt == 0) e_hs_first <= int'(e_x);
                    e_hs_last <= int'(e_x);
                    e_hs_cnt  <= e_hs_cnt + 1;
                end
                if (e_vs) begin
                    if (e_vs_cnt == 0) e_vs_first <= int'(e_y);
                    e_vs_last <= int'(e_y);
                    e_vs_cnt  <= e_vs_cnt + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        n_cmp = 0; n_fail = 0; cyc = 0; run = 1'b0;
        a_hs_cnt = 0; a_hs_first = -1; a_hs_last = -1;
        c_fs_n = 0; c_t0 = 0; c_t1 = 0; c_vs_cnt = 0; c_vs_first = -1; c_vs_last = -1;
        c_disp_cnt = 0; c_disp_bad = 0; c_mask_bad = 0;
        d_fs_n = 0; d_t0 = 0; d_t1 = 0; d_pix_cnt = 0; d_pix_dbl = 0; d_chg_bad = 0;
        d_pix_prev = 1'b0; d_x_prev = 10'd19;
        e_fs_n = 0; e_t0 = 0; e_t1 = 0; e_hs_cnt = 0; e_hs_first = -1; e_hs_last = -1;
        e_vs_cnt = 0; e_vs_first = -1; e_vs_last = -1;
        en_a = 1'b1; en_b = 1'b1; en_c = 1'b1; en_d = 1'b1; en_e = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (20) @(posedge clk);

        // Mid-run reset takes effect without a clock edge
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst_a_x", a_x, 799);
        check("rst_a_y", a_y, 524);
        check("rst_a_hs", a_hs, 1);
        check("rst_a_vs", a_vs, 1);
        check("rst_a_disp", a_disp, 0);
        check("rst_a_px", a_px, 0);
        check("rst_a_py", a_py, 0);
        check("rst_a_pix", a_pix, 0);
        check("rst_a_ls", a_ls, 0);
        check("rst_a_fs", a_fs, 0);
        check("rst_e_x", e_x, 7);
        check("rst_e_y", e_y, 5);
        check("rst_e_hs", e_hs, 0);
        check("rst_e_vs", e_vs, 0);

        @(negedge clk);
        reset = 1'b0;
        run   = 1'b1;

        // First edge after release
        @(posedge clk); #1;
        check("e1_a_x", a_x, 0);
        check("e1_a_y", a_y, 0);
        check("e1_a_fs", a_fs, 1);
        check("e1_a_ls", a_ls, 1);
        check("e1_a_pix", a_pix, 1);
        check("e1_a_disp", a_disp, 1);
        check("e1_a_hs", a_hs, 1);
        check("e1_d_x", d_x, 19);
        check("e1_d_pix", d_pix, 0);
        check("e1_e_fs", e_fs, 1);

        // Second edge: divide-by-two block takes its first tick
        @(posedge clk); #1;
        check("e2_a_x", a_x, 1);
        check("e2_a_fs", a_fs, 0);
        check("e2_a_pix", a_pix, 1);
        check("e2_a_px", a_px, 1);
        check("e2_d_x", d_x, 0);
        check("e2_d_y", d_y, 0);
        check("e2_d_fs", d_fs, 1);
        check("e2_d_pix", d_pix, 1);

        // Line wrap from (799,5)
        n = 0;
        while (!(a_x == 10'd799 && a_y == 10'd5) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("a_wrap_reached", n < 20000, 1);
        @(posedge clk); #1;
        check("wrap_a_x", a_x, 0);
        check("wrap_a_y", a_y, 6);
        check("wrap_a_ls", a_ls, 1);
        check("wrap_a_fs", a_fs, 0);
        check("wrap_a_py", a_py, 6);
        check("a_hs_first", a_hs_first, 656);
        check("a_hs_last", a_hs_last, 751);
        check("a_hs_cnt", a_hs_cnt, 96);

        // Wait for a full frame of the divide-by-two block (covers C and E too)
        n = 0;
        while (d_fs_n < 2 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check("d_frame_reached", n < 30000, 1);
        check("c_frame_len", c_t1 - c_t0, 10500);
        check("c_vs_first", c_vs_first, 490);
        check("c_vs_last", c_vs_last, 491);
        check("c_vs_cnt", c_vs_cnt, 40);
        check("c_disp_cnt", c_disp_cnt, 7680);
        check("c_disp_bad", c_disp_bad, 0);
        check("c_mask_bad", c_mask_bad, 0);
        check("d_frame_len", d_t1 - d_t0, 21000);
        check("d_pix_cnt", d_pix_cnt, 10500);
        check("d_pix_dbl", d_pix_dbl, 0);
        check("d_chg_bad", d_chg_bad, 0);
        check("e_frame_len", e_t1 - e_t0, 48);
        check("e_hs_first", e_hs_first, 5);
        check("e_hs_last", e_hs_last, 6);
        check("e_hs_cnt", e_hs_cnt, 12);
        check("e_vs_first", e_vs_first, 4);
        check("e_vs_last", e_vs_last, 4);
        check("e_vs_cnt", e_vs_cnt, 8);

        // Pause at (100,200) for ten cycles, then resume
        n = 0;
        while (!(b_x == 10'd100 && b_y == 10'd200) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        check("b_pause_reached", n < 30000, 1);
        en_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_x", b_x, 100);
            check("hold_y", b_y, 200);
            check("hold_px", b_px, 100);
            check("hold_py", b_py, 200);
            check("hold_disp", b_disp, 1);
            check("hold_hs", b_hs, 1);
            check("hold_vs", b_vs, 1);
            check("hold_strobes", {b_pix, b_ls, b_fs}, 0);
        end
        @(negedge clk);
        en_b = 1'b1;
        @(posedge clk); #1;
        check("resume_x", b_x, 101);
        check("resume_y", b_y, 200);
        check("resume_pix", b_pix, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
